csa_add_scheduler: RTL and testbench
====================================

Name: csa_add_scheduler

Overview:
Shares one 4-bit carry-select adder slice between two requesters and sequences it over WIDTH-bit operands, one 4-bit chunk per clock, LSB chunk first. Carry is registered between chunks. A round-robin arbiter picks the requester. The result returns on a valid/ready response channel tagged with the requester id. The block sits between client logic and the shared adder datapath.

Parameters:
WIDTH, 16, operand/sum width; multiple of 4, minimum 8; NCH = WIDTH/4 chunks.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operand pair
req0_ready  output  1  requester 0 accepted this cycle
req0_a  input  WIDTH  operand A, requester 0
req0_b  input  WIDTH  operand B, requester 0
req0_cin  input  1  carry-in, requester 0
req1_valid / req1_ready / req1_a / req1_b / req1_cin  same as requester 0, for requester 1
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes result
rsp_id  output  1  requester that owns the result
rsp_sum  output  WIDTH  A+B+Cin, modulo 2^WIDTH
rsp_cout  output  1  carry out of MSB
busy  output  1  state is not IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE, prio=0. All outputs and operand/sum/carry/chunk-index registers are 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - reqN_ready is combinational: high only for the granted requester, and only when its valid is high.
  - Grant rule: if both are valid, grant prio. If one is valid, grant that one.
  - On the handshake edge: capture a, b, cin and id; set k=0; set prio = ~granted id; go to RUN.
- RUN:
  - Each cycle, the slice adds chunk k of a and b, plus the carry register (cin for k=0).
  - The sum chunk is written to rsp_sum[4k+3:4k]; the carry register takes the slice carry-out; k increments.
  - After chunk NCH-1 is registered: rsp_cout = final carry; go to DONE.
  - Both ready outputs stay low.
- DONE:
  - rsp_valid=1; rsp_id/rsp_sum/rsp_cout are held stable while rsp_ready is low.
  - On rsp_valid && rsp_ready: rsp_valid drops and the FSM returns to IDLE.
  - No acceptance in the handshake cycle; one bubble cycle minimum between transactions.
- Latency: rsp_valid rises NCH clocks after the accept edge (4 for WIDTH=16).
- Requests arriving in RUN/DONE wait; valid must stay asserted (standard valid/ready, no drop).
- Arbitration is starvation-free: if both requesters stay valid, grants alternate 0,1,0,1.
- Reset asserted mid-RUN or mid-DONE aborts the transaction: no response, prio returns to 0.
- Width wrap: the sum is truncated to WIDTH; overflow beyond the MSB appears only on rsp_cout.

Optional Feature:
CSA_OVF_EN
- Defined: adds output port rsp_ovf (1 bit), the signed two's-complement overflow of the addition = carry into MSB XOR rsp_cout. It is computed in the last RUN cycle, held with rsp_sum, and reset to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package csa_sched_pkg holds:
  - CHUNK=4 constant.
  - FSM state typedef (IDLE/RUN/DONE).
  - Id typedef.
  - Function nch(width) returning width/CHUNK.
- Sub-module csa_chunk4: purely combinational 4-bit carry-select slice (a[3:0], b[3:0], cin -> sum[3:0], cout). It exposes the bit-3 carry-in only under CSA_OVF_EN. It has a single instance.
- The arbiter and FSM stay in the top module.

Test Plan:
- Single add: req0 A=0x1234, B=0x4321, cin=0 -> req0_ready pulses once; rsp_valid exactly 4 clocks later with sum=0x5555, cout=0, id=0.
- Full carry ripple: req1 A=0xFFFF, B=0x0000, cin=1 -> sum=0x0000, cout=1, id=1. Also A=0xFFFF, B=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
- Contention: both valid from reset with A=0x0001, B=0x0001 (r0) and A=0x0002, B=0x0002 (r1), held valid -> responses in order id 0 (0x0002), 1 (0x0004), 0, 1; never two grants to the same requester while the other is waiting.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE -> rsp_valid/rsp_sum stable, busy=1, both ready outputs low. Raise rsp_ready -> one transfer, then IDLE.
- Reset mid-RUN: drop rst_n at k=2 -> all outputs 0 immediately, no response emitted. After release, req0 0x00FF+0x0001 -> sum=0x0100, id=0.
- CSA_OVF_EN build: 0x7FFF+0x0001 -> sum=0x8000, ovf=1, cout=0. Then 0xFFFF+0x0001 -> sum=0x0000, ovf=0, cout=1.

Source files
------------

// File: rtl/csa_sched_pkg.sv
// Shared definitions for the carry-select add scheduler: chunk width,
// FSM state encoding, requester id type and the chunk-count helper.
package csa_sched_pkg;

  localparam int CHUNK = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef logic id_t;

  // Number of CHUNK-bit slices needed to cover a width-bit operand.
  function automatic int nch(input int width);
    return width / CHUNK;
  endfunction

endpackage

// File: rtl/csa_chunk4.sv
// Purely combinational 4-bit carry-select adder slice.
// Low two bits ripple from cin; the high two bits are precomputed for both
// possible carries into bit 2 and selected once that carry is known.
// Optional macro CSA_OVF_EN: also exposes the carry into bit 3 (c3_o) so the
// caller can derive signed overflow on the top chunk.
module csa_chunk4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
`ifdef CSA_OVF_EN
  ,
  output logic       c3_o
`endif
);

  logic [2:0] lo_sum;
  logic       c2;
  logic [2:0] hi_sum0;
  logic [2:0] hi_sum1;

  assign lo_sum  = {1'b0, a_i[1:0]} + {1'b0, b_i[1:0]} + {2'b00, cin_i};
  assign c2      = lo_sum[2];

  // Both candidate upper results; hi_sum1 assumes a carry into bit 2.
  assign hi_sum0 = {1'b0, a_i[3:2]} + {1'b0, b_i[3:2]};
  assign hi_sum1 = {1'b0, a_i[3:2]} + {1'b0, b_i[3:2]} + 3'd1;

  assign sum_o   = {(c2 ? hi_sum1[1:0] : hi_sum0[1:0]), lo_sum[1:0]};
  assign cout_o  = c2 ? hi_sum1[2] : hi_sum0[2];

`ifdef CSA_OVF_EN
  // Carry into bit 3 for each assumption on c2: generate vs. propagate of bit 2.
  assign c3_o    = c2 ? (a_i[2] | b_i[2]) : (a_i[2] & b_i[2]);
`endif

endmodule

// File: rtl/csa_add_scheduler.sv
// Two-requester scheduler sharing one 4-bit carry-select slice. Operands are
// added one chunk per clock, LSB chunk first, with the carry registered
// between chunks. Round-robin arbitration, valid/ready result channel.
// Optional macro CSA_OVF_EN: adds rsp_ovf, the signed overflow of the sum.
module csa_add_scheduler
  import csa_sched_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
`ifdef CSA_OVF_EN
  output logic             rsp_ovf,
`endif
  output logic             busy
);

  localparam int NCH = nch(WIDTH);
  localparam int KW  = $clog2(NCH);

  state_e           state_q;
  id_t              prio_q;
  id_t              id_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic [KW-1:0]    k_q;

  id_t              grant_id;
  logic             any_valid;
  logic             last_chunk;
  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;

`ifdef CSA_OVF_EN
  logic             ovf_q;
  logic             slice_c3;
`endif

  // Round-robin grant: prio breaks ties, a lone requester always wins.
  assign any_valid  = req0_valid | req1_valid;
  assign grant_id   = (req0_valid && req1_valid) ? prio_q : id_t'(req1_valid);
  assign req0_ready = (state_q == ST_IDLE) && req0_valid && (grant_id == 1'b0);
  assign req1_ready = (state_q == ST_IDLE) && req1_valid && (grant_id == 1'b1);

  // Current chunk of the captured operands feeds the shared slice.
  assign slice_a    = a_q[k_q*CHUNK +: CHUNK];
  assign slice_b    = b_q[k_q*CHUNK +: CHUNK];
  assign last_chunk = (k_q == KW'(NCH - 1));

  csa_chunk4 u_slice (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
`ifdef CSA_OVF_EN
    .c3_o   (slice_c3),
`endif
    .cout_o (slice_cout)
  );

  // Single FSM: accept in IDLE, one chunk per cycle in RUN, hold result in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      k_q     <= '0;
`ifdef CSA_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_valid) begin
            a_q     <= grant_id ? req1_a : req0_a;
            b_q     <= grant_id ? req1_b : req0_b;
            // Loading cin here lets chunk 0 use the carry register like the rest.
            carry_q <= grant_id ? req1_cin : req0_cin;
            id_q    <= grant_id;
            prio_q  <= ~grant_id;
            k_q     <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_q[k_q*CHUNK +: CHUNK] <= slice_sum;
          carry_q <= slice_cout;
          if (last_chunk) begin
            cout_q  <= slice_cout;
`ifdef CSA_OVF_EN
            ovf_q   <= slice_c3 ^ slice_cout;
`endif
            k_q     <= '0;
            state_q <= ST_DONE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
`ifdef CSA_OVF_EN
  assign rsp_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_csa_add_scheduler.sv
// Directed self-checking bench for csa_add_scheduler (WIDTH=16).
module tb_csa_add_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_cin;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cin;
  logic [15:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
  logic [15:0] rsp_sum;
`ifdef CSA_OVF_EN
  logic        rsp_ovf;
`endif

  int n_checks = 0;
  int n_bad    = 0;

  csa_add_scheduler #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
`ifdef CSA_OVF_EN
    .rsp_ovf    (rsp_ovf),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Stimulus only: present one request at a negedge, accept, then wait
  // (bounded) for rsp_valid. Returns ready seen in the request cycle and
  // the number of negedges from the first post-accept negedge to rsp_valid.
  task automatic run_req(input logic id, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, output logic rdy, output int lat);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
    end
    #1 rdy = id ? req1_ready : req0_ready;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_a = 0; req0_b = 0; req0_cin = 0;
    req1_a = 0; req1_b = 0; req1_cin = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({rsp_valid, busy, rsp_id, rsp_cout} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 0000", {rsp_valid, busy, rsp_id, rsp_cout});
    end
    n_checks++;
    if (rsp_sum !== 16'h0000) begin
      n_bad++; $display("FAIL reset_sum: got %h want 0000", rsp_sum);
    end
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_bad++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic rdy; int lat;
    run_req(1'b0, 16'h1234, 16'h4321, 1'b0, rdy, lat);
    n_checks++;
    if (rdy !== 1'b1) begin n_bad++; $display("FAIL single_ready: got %b want 1", rdy); end
    n_checks++;
    if (lat !== 4) begin n_bad++; $display("FAIL single_latency: got %0d want 4", lat); end
    n_checks++;
    if ({rsp_sum, rsp_cout, rsp_id} !== {16'h5555, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL single_result: got sum=%h cout=%b id=%b want sum=5555 cout=0 id=0", rsp_sum, rsp_cout, rsp_id);
    end
    finish_rsp();
    n_checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      n_bad++; $display("FAIL single_idle: got %b want 00", {rsp_valid, busy});
    end
    $display("test_single 1234+4321 sum=%h cout=%b id=%b lat=%0d", rsp_sum, rsp_cout, rsp_id, lat);
  endtask

  task automatic test_carry();
    logic rdy; int lat;
    run_req(1'b1, 16'hFFFF, 16'h0000, 1'b1, rdy, lat);
    n_checks++;
    if ({rsp_sum, rsp_cout, rsp_id} !== {16'h0000, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL carry_ripple: got sum=%h cout=%b id=%b want sum=0000 cout=1 id=1", rsp_sum, rsp_cout, rsp_id);
    end
    $display("test_carry FFFF+0000+1 sum=%h cout=%b", rsp_sum, rsp_cout);
    finish_rsp();
    run_req(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, rdy, lat);
    n_checks++;
    if ({rsp_sum, rsp_cout} !== {16'hFFFF, 1'b1}) begin
      n_bad++;
      $display("FAIL carry_max: got sum=%h cout=%b want sum=FFFF cout=1", rsp_sum, rsp_cout);
    end
    $display("test_carry FFFF+FFFF+1 sum=%h cout=%b", rsp_sum, rsp_cout);
    finish_rsp();
  endtask

  task automatic test_contention();
    int lat;
    logic exp_id;
    logic [15:0] exp_sum;
    rst_n = 1'b0;
    req0_valid = 1; req0_a = 16'h0001; req0_b = 16'h0001; req0_cin = 0;
    req1_valid = 1; req1_a = 16'h0002; req1_b = 16'h0002; req1_cin = 0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int n = 0; n < 4; n++) begin
      exp_id  = n[0];
      exp_sum = exp_id ? 16'h0004 : 16'h0002;
      n_checks++;
      if ({req0_ready, req1_ready} !== {~exp_id, exp_id}) begin
        n_bad++;
        $display("FAIL contention_grant%0d: got %b want %b", n, {req0_ready, req1_ready}, {~exp_id, exp_id});
      end
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!rsp_valid && lat < 20);
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, exp_id, exp_sum}) begin
        n_bad++;
        $display("FAIL contention_rsp%0d: got v=%b id=%b sum=%h want v=1 id=%b sum=%h",
                 n, rsp_valid, rsp_id, rsp_sum, exp_id, exp_sum);
      end
      $display("test_contention rsp %0d id=%b sum=%h lat=%0d", n, rsp_id, rsp_sum, lat);
      if (n == 3) begin
        req0_valid = 0; req1_valid = 0;
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    n_checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      n_bad++; $display("FAIL contention_idle: got %b want 00", {rsp_valid, busy});
    end
  endtask

  task automatic test_backpressure();
    logic rdy; int lat;
    run_req(1'b0, 16'h0100, 16'h0011, 1'b0, rdy, lat);
    req1_valid = 1; req1_a = 16'h0005; req1_b = 16'h0006; req1_cin = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({rsp_valid, busy, req0_ready, req1_ready, rsp_sum, rsp_id} !== {4'b1100, 16'h0111, 1'b0}) begin
        n_bad++;
        $display("FAIL backpressure_hold%0d: got v=%b busy=%b rdy=%b%b sum=%h id=%b want v=1 busy=1 rdy=00 sum=0111 id=0",
                 i, rsp_valid, busy, req0_ready, req1_ready, rsp_sum, rsp_id);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    n_checks++;
    if ({rsp_valid, busy, req1_ready} !== 3'b001) begin
      n_bad++;
      $display("FAIL backpressure_release: got v=%b busy=%b rdy1=%b want 0 0 1", rsp_valid, busy, req1_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req1_valid = 0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if ({rsp_sum, rsp_id, lat} !== {16'h000B, 1'b1, 32'd4}) begin
      n_bad++;
      $display("FAIL backpressure_waiter: got sum=%h id=%b lat=%0d want sum=000b id=1 lat=4", rsp_sum, rsp_id, lat);
    end
    $display("test_backpressure waiter sum=%h id=%b", rsp_sum, rsp_id);
    finish_rsp();
  endtask

  task automatic test_reset_mid_run();
    logic rdy; int lat; int seen;
    req0_valid = 1; req0_a = 16'h1111; req0_b = 16'h2222; req0_cin = 0;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rsp_valid, busy, rsp_cout, rsp_id, rsp_sum} !== {4'b0000, 16'h0000}) begin
      n_bad++;
      $display("FAIL midrun_reset: got v=%b busy=%b cout=%b id=%b sum=%h want all 0",
               rsp_valid, busy, rsp_cout, rsp_id, rsp_sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_bad++; $display("FAIL midrun_no_rsp: got %0d want 0", seen); end
    req0_valid = 1; req1_valid = 1;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_bad++; $display("FAIL midrun_prio: got %b want 10", {req0_ready, req1_ready});
    end
    req0_valid = 0; req1_valid = 0;
    run_req(1'b0, 16'h00FF, 16'h0001, 1'b0, rdy, lat);
    n_checks++;
    if ({rsp_sum, rsp_id, rsp_cout} !== {16'h0100, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL midrun_after: got sum=%h id=%b cout=%b want sum=0100 id=0 cout=0", rsp_sum, rsp_id, rsp_cout);
    end
    $display("test_reset_mid_run after sum=%h id=%b", rsp_sum, rsp_id);
    finish_rsp();
  endtask

`ifdef CSA_OVF_EN
  task automatic test_ovf();
    logic rdy; int lat;
    run_req(1'b0, 16'h7FFF, 16'h0001, 1'b0, rdy, lat);
    n_checks++;
    if ({rsp_sum, rsp_ovf, rsp_cout} !== {16'h8000, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL ovf_pos: got sum=%h ovf=%b cout=%b want sum=8000 ovf=1 cout=0", rsp_sum, rsp_ovf, rsp_cout);
    end
    $display("test_ovf 7FFF+0001 sum=%h ovf=%b cout=%b", rsp_sum, rsp_ovf, rsp_cout);
    finish_rsp();
    run_req(1'b0, 16'hFFFF, 16'h0001, 1'b0, rdy, lat);
    n_checks++;
    if ({rsp_sum, rsp_ovf, rsp_cout} !== {16'h0000, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL ovf_wrap: got sum=%h ovf=%b cout=%b want sum=0000 ovf=0 cout=1", rsp_sum, rsp_ovf, rsp_cout);
    end
    $display("test_ovf FFFF+0001 sum=%h ovf=%b cout=%b", rsp_sum, rsp_ovf, rsp_cout);
    finish_rsp();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_carry();
    test_contention();
    test_backpressure();
    test_reset_mid_run();
`ifdef CSA_OVF_EN
    test_ovf();
`endif
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
